// File: rtl/imem_loader.sv
// imem_loader: assembles a framed byte stream into 32-bit words, writes them
// to instruction RAM and holds the core in reset until the frame verifies.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int unsigned MAX_WORDS      = 1024,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CNT_LO = 3'd1;
    localparam logic [2:0] S_CNT_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_CSUM   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    logic [2:0]    state, state_n;
    logic [15:0]   cnt, cnt_n;
    logic [31:0]   word, word_n;
    logic [1:0]    idx, idx_n;
    logic [7:0]    csum, csum_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          rx_ready_n, mem_we_n, cpu_hold_n, done_n, error_n;
    logic [31:0]   mem_addr_n, mem_wdata_n;
    logic [15:0]   wl_n;

    logic          accept;
    logic [31:0]   word_asm;
    logic [15:0]   count_in;
    logic          timed;

    assign accept = rx_valid & rx_ready;

    // Next-state and next-output logic; every register has its next value here.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        word_n      = word;
        idx_n       = idx;
        csum_n      = csum;
        tcnt_n      = tcnt;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        cpu_hold_n  = cpu_hold;
        done_n      = done;
        error_n     = error;
        wl_n        = words_loaded;

        word_asm = word;
        word_asm[{idx, 3'b000} +: 8] = rx_data;
        count_in = {rx_data, cnt[7:0]};
        timed    = (state == S_CNT_LO) || (state == S_CNT_HI) ||
                   (state == S_DATA)   || (state == S_CSUM);

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_n    = S_CNT_LO;
                    csum_n     = 8'd0;
                    idx_n      = 2'd0;
                    wl_n       = 16'd0;
                    done_n     = 1'b0;
                    error_n    = 1'b0;
                    cpu_hold_n = 1'b1;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    cnt_n   = {cnt[15:8], rx_data};
                    state_n = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    cnt_n = count_in;
                    idx_n = 2'd0;
                    if (32'(count_in) > MAX_WORDS) begin
                        state_n = S_ERR;
                        error_n = 1'b1;
                    end else if (count_in == 16'd0) begin
                        state_n = S_CSUM;
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_n = word_asm;
                    csum_n = csum + rx_data;
                    idx_n  = idx + 2'd1;
                    if (idx == 2'd3) begin
                        state_n     = S_WRITE;
                        mem_we_n    = 1'b1;
                        mem_addr_n  = BASE_ADDR + {14'd0, words_loaded, 2'b00};
                        mem_wdata_n = word_asm;
                    end
                end
            end
            S_WRITE: begin
                wl_n    = words_loaded + 16'd1;
                state_n = (words_loaded + 16'd1 == cnt) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) begin
                    if (rx_data == csum) begin
                        state_n    = S_DONE;
                        done_n     = 1'b1;
                        cpu_hold_n = 1'b0;
                    end else begin
                        state_n = S_ERR;
                        error_n = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Inter-byte timeout, only while a frame is in flight
        if (timed) begin
            if (accept) begin
                tcnt_n = '0;
            end else if (tcnt + TW'(1) == TW'(TIMEOUT_CYCLES)) begin
                state_n = S_ERR;
                error_n = 1'b1;
                tcnt_n  = '0;
            end else begin
                tcnt_n = tcnt + TW'(1);
            end
        end else begin
            tcnt_n = '0;
        end

        rx_ready_n = (state_n != S_WRITE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= 16'd0;
            word         <= 32'd0;
            idx          <= 2'd0;
            csum         <= 8'd0;
            tcnt         <= '0;
            rx_ready     <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= 32'd0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            word         <= word_n;
            idx          <= idx_n;
            csum         <= csum_n;
            tcnt         <= tcnt_n;
            rx_ready     <= rx_ready_n;
            mem_we       <= mem_we_n;
            mem_addr     <= mem_addr_n;
            mem_wdata    <= mem_wdata_n;
            cpu_hold     <= cpu_hold_n;
            done         <= done_n;
            error        <= error_n;
            words_loaded <= wl_n;
        end
    end

endmodule
